// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
// Merges NUM_SLAVE_STREAMS AXI-Stream inputs onto one output. Arbitration is
// round-robin and packet-granular: a granted source keeps the output until its
// tlast beat handshakes. The granted index is published on axis_o_tdest so a
// tdest-routed switch downstream can return responses to the originator.
//
// Ports:
//   clk            clock, rising edge
//   sreset         synchronous active-high reset
//   axis_i_tdata   concatenated input data, stream i at [(i+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8]
//   axis_i_tuser   concatenated input user, same slicing
//   axis_i_tvalid  per-stream valid
//   axis_i_tlast   per-stream last
//   axis_i_tready  per-stream ready (only the granted bit can be set)
//   axis_o_tdata   merged data
//   axis_o_tuser   merged user
//   axis_o_tvalid  merged valid
//   axis_o_tlast   merged last
//   axis_o_tready  downstream ready
//   axis_o_tdest   index of the granted source
module axis_rr_arbiter #(
   parameter int unsigned AXIS_BYTES        = 1,
   parameter int unsigned AXIS_USER_BITS    = 1,
   parameter int unsigned NUM_SLAVE_STREAMS = 2,
   localparam int unsigned AXIS_DEST_BITS   = (NUM_SLAVE_STREAMS == 1) ? 1 : $clog2(NUM_SLAVE_STREAMS)
) (
   input  logic                                           clk,
   input  logic                                           sreset,
   input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0]      axis_i_tdata,
   input  logic [NUM_SLAVE_STREAMS*AXIS_USER_BITS-1:0]    axis_i_tuser,
   input  logic [NUM_SLAVE_STREAMS-1:0]                   axis_i_tvalid,
   input  logic [NUM_SLAVE_STREAMS-1:0]                   axis_i_tlast,
   output logic [NUM_SLAVE_STREAMS-1:0]                   axis_i_tready,
   output logic [AXIS_BYTES*8-1:0]                        axis_o_tdata,
   output logic [AXIS_USER_BITS-1:0]                      axis_o_tuser,
   output logic                                           axis_o_tvalid,
   output logic                                           axis_o_tlast,
   input  logic                                           axis_o_tready,
   output logic [AXIS_DEST_BITS-1:0]                      axis_o_tdest
);

   localparam int unsigned DATA_W = AXIS_BYTES * 8;
   localparam int unsigned USER_W = AXIS_USER_BITS;
   localparam int unsigned NS     = NUM_SLAVE_STREAMS;
   localparam int unsigned SUM_W  = AXIS_DEST_BITS + 1;

   // Stream count at the width of the modulo adder below.
   localparam logic [SUM_W-1:0] NS_W = SUM_W'(NUM_SLAVE_STREAMS);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                    state;
   state_t                    state_n;
   logic [AXIS_DEST_BITS-1:0] grant;
   logic [AXIS_DEST_BITS-1:0] grant_n;
   logic [AXIS_DEST_BITS-1:0] last_grant;
   logic [AXIS_DEST_BITS-1:0] last_grant_n;

   logic                      rr_found;
   logic [AXIS_DEST_BITS-1:0] rr_pick;
   logic [SUM_W-1:0]          rr_sum;

   logic [DATA_W-1:0]         sel_data;
   logic [USER_W-1:0]         sel_user;
   logic                      sel_valid;
   logic                      sel_last;
   logic [NS-1:0]             sel_onehot;
   logic                      pkt_done;

   // Round-robin search: last_grant+1, last_grant+2, ... wrapping modulo NS,
   // so last_grant itself is the final candidate. Since last_grant < NS and
   // the offset is <= NS, one conditional subtract implements the modulo.
   always_comb begin : rr_search
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_sum   = '0;
      for (int unsigned k = 1; k <= NS; k++) begin
         rr_sum = {1'b0, last_grant} + SUM_W'(k);
         if (rr_sum >= NS_W) begin
            rr_sum = rr_sum - NS_W;
         end
         if (!rr_found && axis_i_tvalid[rr_sum[AXIS_DEST_BITS-1:0]]) begin
            rr_found = 1'b1;
            rr_pick  = rr_sum[AXIS_DEST_BITS-1:0];
         end
      end
   end

   // Input mux steered by the grant register.
   always_comb begin : grant_mux
      sel_data   = '0;
      sel_user   = '0;
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      sel_onehot = '0;
      for (int unsigned i = 0; i < NS; i++) begin
         if (grant == AXIS_DEST_BITS'(i)) begin
            sel_data      = axis_i_tdata[i*DATA_W +: DATA_W];
            sel_user      = axis_i_tuser[i*USER_W +: USER_W];
            sel_valid     = axis_i_tvalid[i];
            sel_last      = axis_i_tlast[i];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   assign pkt_done = sel_valid & axis_o_tready & sel_last;

   // State register; reset hands first priority to stream 0.
   always_ff @(posedge clk) begin : state_reg
      if (sreset) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= AXIS_DEST_BITS'(NS - 1);
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         last_grant <= last_grant_n;
      end
   end

   // Next-state: grant is only loaded in IDLE, so it cannot move mid-packet.
   always_comb begin : next_state
      state_n      = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      case (state)
         IDLE: begin
            if (rr_found) begin
               grant_n = rr_pick;
               state_n = LOCKED;
            end
         end
         LOCKED: begin
            if (pkt_done) begin
               last_grant_n = grant;
               state_n      = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Outputs: data/user/dest always follow grant; handshake lines are gated
   // by LOCKED so the IDLE arbitration cycle is a bubble on both sides.
   always_comb begin : out_comb
      axis_o_tdata  = sel_data;
      axis_o_tuser  = sel_user;
      axis_o_tdest  = grant;
      axis_o_tvalid = 1'b0;
      axis_o_tlast  = 1'b0;
      axis_i_tready = '0;
      if (state == LOCKED) begin
         axis_o_tvalid = sel_valid;
         axis_o_tlast  = sel_last;
         axis_i_tready = sel_onehot & {NS{axis_o_tready}};
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter with four 8-bit streams.
module tb_axis_rr_arbiter;

   localparam int unsigned NS = 4;

   logic          clk;
   logic          sreset;
   logic [31:0]   axis_i_tdata;
   logic [3:0]    axis_i_tuser;
   logic [3:0]    axis_i_tvalid;
   logic [3:0]    axis_i_tlast;
   logic [3:0]    axis_i_tready;
   logic [7:0]    axis_o_tdata;
   logic [0:0]    axis_o_tuser;
   logic          axis_o_tvalid;
   logic          axis_o_tlast;
   logic          axis_o_tready;
   logic [1:0]    axis_o_tdest;

   axis_rr_arbiter #(
      .AXIS_BYTES        (1),
      .AXIS_USER_BITS    (1),
      .NUM_SLAVE_STREAMS (NS)
   ) dut (
      .clk           (clk),
      .sreset        (sreset),
      .axis_i_tdata  (axis_i_tdata),
      .axis_i_tuser  (axis_i_tuser),
      .axis_i_tvalid (axis_i_tvalid),
      .axis_i_tlast  (axis_i_tlast),
      .axis_i_tready (axis_i_tready),
      .axis_o_tdata  (axis_o_tdata),
      .axis_o_tuser  (axis_o_tuser),
      .axis_o_tvalid (axis_o_tvalid),
      .axis_o_tlast  (axis_o_tlast),
      .axis_o_tready (axis_o_tready),
      .axis_o_tdest  (axis_o_tdest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       user;
      logic       last;
      logic [1:0] dest;
   } beat_t;

   beat_t src_q [NS][$];
   beat_t exp_q [$];
   int    hs_cyc [$];
   logic [3:0] pause;
   int    cyc;
   int    n_total;
   int    n_bad;

   // Snapshot of the current and previous cycle, taken on the falling edge.
   logic       snap_valid, snap_oready, snap_rst, snap_last;
   logic [3:0] snap_ready;
   logic [1:0] snap_dest;
   logic [7:0] snap_data;
   logic       prev_valid, prev_oready, prev_rst, prev_last;
   logic [1:0] prev_dest;
   logic [7:0] prev_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic beat_t mk_beat(input int src, input logic [7:0] base, input int k, input int len);
      beat_t b;
      b.data = base + 8'(k);
      b.user = 1'(k) ^ 1'(src);
      b.last = (k == len - 1);
      b.dest = 2'(src);
      return b;
   endfunction

   task automatic add_pkt(input int src, input int len, input logic [7:0] base);
      for (int k = 0; k < len; k++) src_q[src].push_back(mk_beat(src, base, k, len));
   endtask

   task automatic exp_pkt(input int src, input int len, input logic [7:0] base, input int first);
      for (int k = first; k < len; k++) exp_q.push_back(mk_beat(src, base, k, len));
   endtask

   task automatic drive();
      beat_t b;
      for (int i = 0; i < int'(NS); i++) begin
         if (src_q[i].size() > 0 && !pause[i]) begin
            b = src_q[i][0];
            axis_i_tvalid[i]         = 1'b1;
            axis_i_tdata[i*8 +: 8]   = b.data;
            axis_i_tuser[i]          = b.user;
            axis_i_tlast[i]          = b.last;
         end else begin
            axis_i_tvalid[i] = 1'b0;
            axis_i_tlast[i]  = 1'b0;
         end
      end
   endtask

   // One clock: observe at the falling edge, then present new input beats
   // just after the rising edge.
   task automatic tick();
      beat_t got;
      beat_t e;
      @(negedge clk);
      prev_valid  = snap_valid;
      prev_oready = snap_oready;
      prev_rst    = snap_rst;
      prev_last   = snap_last;
      prev_dest   = snap_dest;
      prev_data   = snap_data;
      snap_valid  = axis_o_tvalid;
      snap_oready = axis_o_tready;
      snap_rst    = sreset;
      snap_last   = axis_o_tlast;
      snap_dest   = axis_o_tdest;
      snap_data   = axis_o_tdata;
      snap_ready  = axis_i_tready;
      if (snap_valid)
         chk("rdy_mirror", 32'(snap_ready), 32'(snap_oready ? (4'd1 << snap_dest) : 4'd0));
      if (prev_valid && !prev_oready && !prev_rst) begin
         chk("hold_valid", 32'(snap_valid), 32'd1);
         chk("hold_beat", 32'({snap_data, snap_last, snap_dest}), 32'({prev_data, prev_last, prev_dest}));
      end
      if (axis_o_tvalid && axis_o_tready) begin
         got = {axis_o_tdata, axis_o_tuser, axis_o_tlast, axis_o_tdest};
         if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(got), 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            chk("beat", 32'(got), 32'(e));
         end
         hs_cyc.push_back(cyc);
      end
      for (int i = 0; i < int'(NS); i++)
         if (axis_i_tvalid[i] && axis_i_tready[i]) void'(src_q[i].pop_front());
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic run(input int budget, input string tag);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < int'(NS); i++) src_q[i].delete();
      exp_q.delete();
      pause = '0;
      drive();
      sreset = 1'b1;
      tick();
      sreset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c0;
      logic [3:0] pat;
      n_total = 0;
      n_bad = 0;
      cyc = 0;
      pause = '0;
      sreset = 1'b1;
      axis_o_tready = 1'b1;
      axis_i_tdata = '0;
      axis_i_tuser = '0;
      axis_i_tvalid = '0;
      axis_i_tlast = '0;
      snap_valid = 1'b0; snap_oready = 1'b0; snap_rst = 1'b1; snap_last = 1'b0;
      snap_dest = '0; snap_data = '0; snap_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      sreset = 1'b0;

      // Reset state.
      tick();
      chk("rst_valid", 32'(snap_valid), 32'd0);
      chk("rst_ready", 32'(snap_ready), 32'd0);
      chk("rst_dest",  32'(snap_dest),  32'd0);

      // Single source: stream 2, 3 beats, one bubble then back-to-back beats.
      hs_cyc.delete();
      exp_pkt(2, 3, 8'h10, 0);
      add_pkt(2, 3, 8'h10);
      drive();
      c0 = cyc;
      run(20, "s1");
      chk("s1_beats", 32'(hs_cyc.size()), 32'd3);
      if (hs_cyc.size() == 3) begin
         chk("s1_first", 32'(hs_cyc[0] - c0), 32'd1);
         chk("s1_span",  32'(hs_cyc[2] - hs_cyc[0]), 32'd2);
      end
      tick();
      chk("s1_idle", 32'(snap_valid), 32'd0);

      // Round robin from reset: 0,1,2,3 then stream 0's second packet.
      do_reset();
      hs_cyc.delete();
      for (int s = 0; s < 4; s++) begin
         add_pkt(s, 2, 8'(8'h20 + 8'(16 * s)));
         exp_pkt(s, 2, 8'(8'h20 + 8'(16 * s)), 0);
      end
      add_pkt(0, 2, 8'h80);
      exp_pkt(0, 2, 8'h80, 0);
      drive();
      run(60, "s2");
      chk("s2_beats", 32'(hs_cyc.size()), 32'd10);
      if (hs_cyc.size() == 10)
         for (int k = 0; k < 9; k++)
            chk("s2_gap", 32'(hs_cyc[k+1] - hs_cyc[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

      // Lock on packet: stream 1 stalls mid-packet while stream 0 waits.
      add_pkt(1, 4, 8'h40);
      add_pkt(0, 2, 8'h50);
      exp_pkt(1, 4, 8'h40, 0);
      exp_pkt(0, 2, 8'h50, 0);
      drive();
      n = 0;
      while (src_q[1].size() > 3 && n < 20) begin
         tick();
         n++;
      end
      chk("s3_progress", 32'(src_q[1].size()), 32'd3);
      pause[1] = 1'b1;
      drive();
      repeat (3) begin
         tick();
         chk("s3_valid", 32'(snap_valid), 32'd0);
         chk("s3_dest",  32'(snap_dest),  32'd1);
      end
      pause[1] = 1'b0;
      drive();
      run(40, "s3");

      // Backpressure: downstream ready cycles 1,0,0,1 across a 4-beat packet.
      add_pkt(2, 4, 8'h60);
      exp_pkt(2, 4, 8'h60, 0);
      drive();
      pat = 4'b1001;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         axis_o_tready = pat[n % 4];
         tick();
         n++;
      end
      chk("s4_drained", 32'(exp_q.size()), 32'd0);
      axis_o_tready = 1'b1;

      // Reset mid-packet: stream 3 abandoned after 2 of 5 beats.
      add_pkt(3, 5, 8'h70);
      exp_pkt(3, 5, 8'h70, 0);
      drive();
      n = 0;
      while (src_q[3].size() > 3 && n < 20) begin
         tick();
         n++;
      end
      chk("s5_progress", 32'(src_q[3].size()), 32'd3);
      axis_o_tready = 1'b0;
      sreset = 1'b1;
      tick();
      sreset = 1'b0;
      axis_o_tready = 1'b1;
      exp_q.delete();
      exp_pkt(0, 2, 8'h90, 0);
      exp_pkt(3, 5, 8'h70, 2);
      add_pkt(0, 2, 8'h90);
      drive();
      tick();
      chk("s5_valid", 32'(snap_valid), 32'd0);
      chk("s5_ready", 32'(snap_ready), 32'd0);
      run(40, "s5");

      // Skip idle sources: set last_grant=1, then only streams 1 and 3 request.
      add_pkt(1, 1, 8'ha0);
      exp_pkt(1, 1, 8'ha0, 0);
      drive();
      run(20, "s6a");
      hs_cyc.delete();
      add_pkt(3, 1, 8'hb0);
      add_pkt(3, 1, 8'hb1);
      add_pkt(1, 1, 8'hc0);
      add_pkt(1, 1, 8'hc1);
      exp_pkt(3, 1, 8'hb0, 0);
      exp_pkt(1, 1, 8'hc0, 0);
      exp_pkt(3, 1, 8'hb1, 0);
      exp_pkt(1, 1, 8'hc1, 0);
      drive();
      run(40, "s6");
      chk("s6_beats", 32'(hs_cyc.size()), 32'd4);
      if (hs_cyc.size() == 4)
         for (int k = 0; k < 3; k++)
            chk("s6_gap", 32'(hs_cyc[k+1] - hs_cyc[k]), 32'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
